// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
// Bit-serial adder controller. One full-adder cell is reused across a
// WIDTH-bit addition, one bit per clock, LSB first.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   start_valid  requester presents operands
//   start_ready  block can accept operands (IDLE)
//   A, B, Cin    operands, sampled only on the accept edge
//   busy         high while an addition is in progress
//   done         one-cycle pulse when S/Cout hold a new result
//   S, Cout      registered sum and carry-out, held until the next result
module serial_add_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept_c;
   logic             last_c;

   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] sh_s;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             fa_sum_c;
   logic             fa_cout_c;

   // Single full-adder cell fed by the operand LSBs and the carry flop
   always_comb begin
      fa_sum_c  = sh_a[0] ^ sh_b[0] ^ carry;
      fa_cout_c = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      case (state)
         IDLE: begin
            if (start_valid) begin
               accept_c  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == CNT_LAST) begin
               last_c    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and registered status outputs (decoded from the next state)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_ready <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         sh_a        <= '0;
         sh_b        <= '0;
         sh_s        <= '0;
         carry       <= 1'b0;
         cnt         <= '0;
         S           <= '0;
         Cout        <= 1'b0;
      end else begin
         start_ready <= (state_nxt == IDLE);
         busy        <= (state_nxt == RUN);
         done        <= (state_nxt == DONE);
         if (accept_c) begin
            sh_a  <= A;
            sh_b  <= B;
            carry <= Cin;
            cnt   <= '0;
         end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            sh_s  <= {fa_sum_c, sh_s[WIDTH-1:1]};
            carry <= fa_cout_c;
            cnt   <= cnt + CNT_W'(1);
            // Shadow register keeps S/Cout stable until the whole sum is known
            if (last_c) begin
               S    <= {fa_sum_c, sh_s[WIDTH-1:1]};
               Cout <= fa_cout_c;
            end
         end
      end
   end

endmodule
